// File: rtl/serial_signed_addsub_if.sv
// Operand/result bundle for the bit-serial signed adder/subtractor.
// The master requests operations; the slave (datapath) reports status and results.
interface serial_signed_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             carry_out;

    modport master (
        output start, op, a, b,
        input  busy, done, result, overflow, carry_out
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, overflow, carry_out
    );
endinterface

// File: rtl/serial_signed_addsub.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per clock.
// The full-adder cell is two half_adder cells plus an OR gate.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    always_comb begin
        s = x ^ y;
        c = x & y;
    end
endmodule

module serial_signed_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_signed_addsub_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [WIDTH-1:0] result_q;
    logic             overflow_q;
    logic             carry_out_q;

    logic             s0, c0, s, c1;
    logic             carry_nxt;
    logic [WIDTH-1:0] acc_nxt;

    half_adder u_ha0 (.x(opa[0]), .y(opb[0]), .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0),     .y(carry),  .s(s),  .c(c1));

    always_comb begin
        carry_nxt = c0 | c1;
        acc_nxt   = {s, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            opa         <= '0;
            opb         <= '0;
            acc         <= '0;
            carry       <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction runs as a + ~b + 1: invert b, seed carry with 1.
                        opa   <= bus.a;
                        opb   <= bus.op ? ~bus.b : bus.b;
                        carry <= bus.op;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= {1'b0, opa[WIDTH-1:1]};
                    opb   <= {1'b0, opb[WIDTH-1:1]};
                    carry <= carry_nxt;
                    acc   <= acc_nxt;
                    if (cnt == LAST) begin
                        // carry here is the carry into the MSB; overflow when it differs from carry out.
                        result_q    <= acc_nxt;
                        carry_out_q <= carry_nxt;
                        overflow_q  <= carry ^ carry_nxt;
                        cnt         <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state == RUN);
        bus.done      = (state == DONE);
        bus.result    = result_q;
        bus.overflow  = overflow_q;
        bus.carry_out = carry_out_q;
    end
endmodule

// File: tb/tb_serial_signed_addsub.sv
// Randomized and directed bench for serial_signed_addsub against an arithmetic reference.
module tb_serial_signed_addsub;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [W-1:0] held_r;
    logic         held_ov;
    logic         held_co;

    serial_signed_addsub_if #(.WIDTH(W)) bus ();

    serial_signed_addsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: true signed result from integer arithmetic, carry from unsigned view.
    function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iop,
                                  output logic [W-1:0] r, output logic ov, output logic co);
        int sa;
        int sb;
        int t;
        int ua;
        int ub;
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        ua = int'(ia);
        ub = int'(ib);
        t  = iop ? (sa - sb) : (sa + sb);
        r  = t[W-1:0];
        ov = (t < -(2 ** (W - 1))) || (t > (2 ** (W - 1)) - 1);
        co = iop ? (ua >= ub) : ((ua + ub) >= (2 ** W));
    endfunction

    task automatic check_outputs_held(input string tag);
        check({tag, "_result"}, 32'(bus.result),    32'(held_r));
        check({tag, "_ovf"},    32'(bus.overflow),  32'(held_ov));
        check({tag, "_cout"},   32'(bus.carry_out), 32'(held_co));
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the DONE cycle.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iop,
                          input int inject_at, input bit inject_done);
        logic [W-1:0] er;
        logic         eov;
        logic         eco;
        int           cyc;
        bit           seen;
        model(ia, ib, iop, er, eov, eco);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        bus.op    = iop;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.op    = 1'($urandom);
        check("busy_rise", 32'(bus.busy), 32'd1);
        check_outputs_held("hold_e0");
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < W + 4) begin
            if (inject_at > 0 && cyc == inject_at) begin
                bus.start = 1'b1;
                bus.a     = W'(1);
                bus.b     = W'(1);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                check("busy_run", 32'(bus.busy), 32'd1);
                check_outputs_held("hold_run");
            end
        end
        bus.start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(cyc), 32'(W));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("result", 32'(bus.result), 32'(er));
        check("overflow", 32'(bus.overflow), 32'(eov));
        check("carry_out", 32'(bus.carry_out), 32'(eco));
        held_r  = er;
        held_ov = eov;
        held_co = eco;
        if (inject_done) begin
            bus.start = 1'b1;
            bus.a     = W'(1);
            bus.b     = W'(1);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("done_pulse_end", 32'(bus.done), 32'd0);
        check("busy_after", 32'(bus.busy), 32'd0);
        check_outputs_held("hold_after");
        if (inject_done) begin
            @(negedge clk);
            check("done_start_ignored_busy", 32'(bus.busy), 32'd0);
            check("done_start_ignored_done", 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        held_r    = '0;
        held_ov   = 1'b0;
        held_co   = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check_outputs_held("rst");
        rst = 1'b0;
        @(negedge clk);

        run_op(8'd5,   8'd3,   1'b0, 0, 1'b0);
        run_op(8'd127, 8'd1,   1'b0, 0, 1'b0);
        run_op(8'h80,  8'd1,   1'b1, 0, 1'b0);
        run_op(8'hFB,  8'hFB,  1'b1, 0, 1'b0);
        run_op(8'h80,  8'h80,  1'b0, 0, 1'b0);
        run_op(8'd0,   8'h80,  1'b1, 0, 1'b0);
        run_op(8'd0,   8'd0,   1'b1, 0, 1'b0);

        // Starts during RUN and during DONE are dropped; the next one after returns to IDLE is taken.
        run_op(8'd10, 8'd20, 1'b0, 3, 1'b1);
        run_op(8'd7,  8'd9,  1'b1, 0, 1'b0);

        // Abort mid-run: outputs clear asynchronously, no done pulse.
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd100;
        bus.op    = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        held_r  = '0;
        held_ov = 1'b0;
        held_co = 1'b0;
        check_outputs_held("abort");
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_done", 32'(bus.done), 32'd0);
        run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 2)) : 0,
                   ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
